// File: rtl/vga_frame_timing.sv
// vga_frame_timing
// ----------------
// Raster timing and frame synchronisation for the renderer. Produces the
// pixel/line counters, the undelayed active-video qualifier, sync pulses
// delayed to match the renderer's output register, a frame-start pulse and a
// completed-frame counter. Also double-buffers the vertex matrix: a producer
// may deliver a matrix at any time, but it is only committed to the renderer
// at the start of vertical blanking so no frame mixes two matrices.
//
// Ports:
//   pclk          in   pixel clock
//   rst           in   asynchronous active-high reset
//   h_cnt         out  horizontal pixel counter (0..H_TOTAL-1)
//   v_cnt         out  vertical line counter (0..V_TOTAL-1)
//   VGAvalid      out  active-video qualifier, same cycle as counters
//   hsync, vsync  out  active-low syncs, delayed PIPE_DLY cycles
//   frame_start   out  one-cycle pulse at (0,0), not after reset
//   frame_cnt     out  completed-frame counter, wraps mod 2^16
//   mtx_wr_*      in/out  matrix write handshake (valid/ready) and payload
//   mtrxIn        out  committed matrix to the renderer
//   matrixState   out  committed state tag to the renderer

module vga_frame_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 1
) (
    input  logic         pclk,
    input  logic         rst,
    output logic [9:0]   h_cnt,
    output logic [9:0]   v_cnt,
    output logic         VGAvalid,
    output logic         hsync,
    output logic         vsync,
    output logic         frame_start,
    output logic [15:0]  frame_cnt,
    input  logic         mtx_wr_valid,
    output logic         mtx_wr_ready,
    input  logic [335:0] mtx_wr_data,
    input  logic [3:0]   mtx_wr_state,
    output logic [335:0] mtrxIn,
    output logic [3:0]   matrixState
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic line_end;
    logic frame_end;

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign VGAvalid = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // ------------------------------------------------------------------
    // Sync decode and alignment delay
    // ------------------------------------------------------------------
    logic hsync_raw;
    logic vsync_raw;
    logic [PIPE_DLY-1:0] hs_pipe;
    logic [PIPE_DLY-1:0] vs_pipe;

    assign hsync_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vsync_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            hs_pipe[0] <= hsync_raw;
            vs_pipe[0] <= vsync_raw;
            for (int i = 1; i < PIPE_DLY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
        end
    end

    assign hsync = hs_pipe[PIPE_DLY-1];
    assign vsync = vs_pipe[PIPE_DLY-1];

    // ------------------------------------------------------------------
    // Frame pulse and counter. Both are driven by the full-raster wrap, so
    // the (0,0) right after reset (not reached by a wrap) never pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= frame_end;
            if (frame_end) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Matrix buffer
    // Handshake: a transfer happens on a rising pclk edge where
    // mtx_wr_valid && mtx_wr_ready. While ready is low the producer must
    // hold valid and data stable; the block ignores it until ready returns.
    // ------------------------------------------------------------------
    typedef enum logic {
        MTX_EMPTY   = 1'b0,
        MTX_PENDING = 1'b1
    } mtx_state_t;

    mtx_state_t mtx_state;
    mtx_state_t mtx_next;
    logic       commit_pt;
    logic       accept;
    logic       commit;
    logic [335:0] pend_data;
    logic [3:0]   pend_state;

    // Last pixel of the last active line: the edge leaving it starts
    // vertical blanking.
    assign commit_pt = line_end && (v_cnt == V_ACT_LAST);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) mtx_state <= MTX_EMPTY;
        else     mtx_state <= mtx_next;
    end

    always_comb begin
        mtx_next     = mtx_state;
        mtx_wr_ready = 1'b0;
        accept       = 1'b0;
        commit       = 1'b0;
        case (mtx_state)
            MTX_EMPTY: begin
                mtx_wr_ready = 1'b1;
                // A write landing on the commit point is only captured; it
                // waits for the next frame's commit.
                if (mtx_wr_valid) begin
                    accept   = 1'b1;
                    mtx_next = MTX_PENDING;
                end
            end
            MTX_PENDING: begin
                if (commit_pt) begin
                    commit   = 1'b1;
                    mtx_next = MTX_EMPTY;
                end
            end
            default: mtx_next = MTX_EMPTY;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pend_data   <= '0;
            pend_state  <= '0;
            mtrxIn      <= '0;
            matrixState <= '0;
        end else begin
            if (accept) begin
                pend_data  <= mtx_wr_data;
                pend_state <= mtx_wr_state;
            end
            if (commit) begin
                mtrxIn      <= pend_data;
                matrixState <= pend_state;
            end
        end
    end

endmodule
